// File: rtl/sensor_frontend.sv
// Ambient-light ADC reader (3-wire serial) plus PIR/IR debounce and motion hold.
// Define LUM_AVG_EN to report a 4-sample running average instead of the raw reading.
module sensor_frontend #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int DEB_CYCLES    = 8,
  parameter int MOTION_HOLD   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adc_sdo,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  input  logic       pir_raw,
  input  logic       ir_raw,
  output logic [7:0] lum_sen,
  output logic       lum_valid,
  output logic       motion_sen,
  output logic       ir_sen
);
  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(MOTION_HOLD + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(MOTION_HOLD);

  typedef enum logic [1:0] {IDLE, SELECT, SHIFT, DONE} adcState_e;

  adcState_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic          sclkHigh_q, sclkHigh_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    lum_q, lum_d;
  logic          loadLum;

  // Index 0 carries the PIR channel, index 1 the IR channel.
  logic [1:0]    sync1_q, sync2_q, deb_q, deb_d;
  logic [BW-1:0] debCnt_q [2];
  logic [BW-1:0] debCnt_d [2];
  logic [HW-1:0] hold_q, hold_d;

  assign timer_d = (timer_q == TIMER_LAST) ? '0 : timer_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sclkHigh_d = sclkHigh_q;
    shift_d    = shift_q;
    loadLum    = 1'b0;
    case (state_q)
      IDLE: begin
        if (timer_q == TIMER_LAST) begin
          state_d = SELECT;
          div_d   = '0;
        end
      end
      SELECT: begin
        if (div_q == DIV_LAST) begin
          state_d    = SHIFT;
          div_d      = '0;
          bit_d      = '0;
          sclkHigh_d = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d      = '0;
          sclkHigh_d = !sclkHigh_q;
          // Data is captured on the same edge that raises sclk.
          if (!sclkHigh_q) begin
            shift_d = {shift_q[6:0], adc_sdo};
          end else if (bit_q == 3'd7) begin
            state_d = DONE;
            loadLum = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef LUM_AVG_EN
  // Three previous results plus the incoming one form the 4-entry window.
  logic [7:0] win_q [3];
  logic [9:0] winSum;

  always_comb begin
    winSum = 10'(win_q[0]) + 10'(win_q[1]) + 10'(win_q[2]) + 10'(shift_q);
    lum_d  = loadLum ? 8'(winSum >> 2) : lum_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) win_q[i] <= '0;
    end else if (loadLum) begin
      win_q[0] <= shift_q;
      win_q[1] <= win_q[0];
      win_q[2] <= win_q[1];
    end
  end
`else
  assign lum_d = loadLum ? shift_q : lum_q;
`endif

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]    = deb_q[i];
      debCnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (debCnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else debCnt_d[i] = debCnt_q[i] + 1'b1;
      end
    end
    if (deb_q[0]) hold_d = HOLD_LOAD;
    else if (hold_q != '0) hold_d = hold_q - 1'b1;
    else hold_d = hold_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      sclkHigh_q <= 1'b0;
      shift_q    <= '0;
      lum_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      for (int i = 0; i < 2; i++) debCnt_q[i] <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sclkHigh_q <= sclkHigh_d;
      shift_q    <= shift_d;
      lum_q      <= lum_d;
      sync1_q    <= {ir_raw, pir_raw};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      for (int i = 0; i < 2; i++) debCnt_q[i] <= debCnt_d[i];
      hold_q     <= hold_d;
    end
  end

  assign adc_cs_n   = !((state_q == SELECT) || (state_q == SHIFT));
  assign adc_sclk   = (state_q == SHIFT) && sclkHigh_q;
  assign lum_sen    = lum_q;
  assign lum_valid  = (state_q == DONE);
  assign ir_sen     = deb_q[1];
  assign motion_sen = deb_q[0] | (hold_q != '0);
endmodule

// File: tb/tb_sensor_frontend.sv
// Self-checking bench for sensor_frontend: timing/debounce/hold model compared every cycle,
// plus directed scenarios with hand-computed results (also covers LUM_AVG_EN builds).
module tb_sensor_frontend;
  localparam int CD       = 4;
  localparam int SP       = 200;
  localparam int DEB      = 8;
  localparam int MH       = 64;
  localparam int CONV_LOW = 17 * CD;

`ifdef LUM_AVG_EN
  localparam int EXP_FIRST = 8'h20, EXP_SECOND = 8'h22, EXP_ABORT = 8'h29;
  localparam int EXP_SEQ [5] = '{25, 50, 75, 100, 75};
`else
  localparam int EXP_FIRST = 8'h80, EXP_SECOND = 8'h08, EXP_ABORT = 8'hA5;
  localparam int EXP_SEQ [5] = '{100, 100, 100, 100, 0};
`endif
  localparam int SEQ_WORDS [5] = '{100, 100, 100, 100, 0};

  logic clk = 1'b0;
  logic reset, pir_raw, ir_raw;
  logic adc_sdo = 1'b0;
  logic adc_cs_n, adc_sclk, lum_valid, motion_sen, ir_sen;
  logic [7:0] lum_sen;
  logic dfltSdo = 1'b0;
  logic dfltCs, dfltSclk, dfltValid, dfltMotion, dfltIr;
  logic [7:0] dfltLum;
  logic [7:0] adcWord = 8'h00;

  int nCompared = 0, nMismatched = 0;

  sensor_frontend #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .DEB_CYCLES(DEB), .MOTION_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .adc_sdo(adc_sdo), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .pir_raw(pir_raw), .ir_raw(ir_raw), .lum_sen(lum_sen), .lum_valid(lum_valid),
    .motion_sen(motion_sen), .ir_sen(ir_sen));

  // Default-parameter copy, used for the reset-to-first-conversion timing.
  sensor_frontend dutDefault (
    .clk(clk), .reset(reset), .adc_sdo(dfltSdo), .adc_cs_n(dfltCs), .adc_sclk(dfltSclk),
    .pir_raw(pir_raw), .ir_raw(ir_raw), .lum_sen(dfltLum), .lum_valid(dfltValid),
    .motion_sen(dfltMotion), .ir_sen(dfltIr));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic pir, input logic ir);
    pir_raw = pir;
    ir_raw  = ir;
  endtask

  // ADC device model: presents the MSB on select, next bit after every falling sclk.
  int sdoIdx = 8;
  always @(adc_cs_n or adc_sclk) begin
    if (adc_cs_n === 1'b1) begin
      sdoIdx = 8;
    end else if (adc_cs_n === 1'b0 && adc_sclk === 1'b0 && sdoIdx > 0) begin
      sdoIdx--;
      adc_sdo = adcWord[3'(sdoIdx)];
    end
  end

  // Reference model, advanced once per rising edge from the stated timing rules.
  bit modelOn = 0;
  int n, k, convWord, expLum, sinceFall;
  bit conv, expValid, expCs, expSclk, debPir, debIr;
  logic [DEB:0] histPir, histIr;
  int win [$];

  function automatic bit debFlip(input logic [DEB:0] h, input bit d);
    bit allDiffer = 1'b1;
    for (int j = 1; j <= DEB; j++) if (h[j] == d) allDiffer = 1'b0;
    return allDiffer;
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      modelOn = 1; n = 0; expLum = 0; expValid = 0; expCs = 1; expSclk = 0;
      histPir = '0; histIr = '0; debPir = 0; debIr = 0; sinceFall = MH + 1;
      win = '{0, 0, 0, 0};
    end else if (modelOn) begin
      n++;
      k = n % SP;
      conv = (n >= SP);
      if (conv && k == 0) convWord = adcWord;
      expValid = conv && (k == CONV_LOW);
      expCs = !(conv && k < CONV_LOW);
      expSclk = conv && k >= CD && k < CONV_LOW && (((k - CD) / CD) % 2 == 1);
      if (expValid) begin
`ifdef LUM_AVG_EN
        win.push_back(convWord);
        void'(win.pop_front());
        expLum = (win[0] + win[1] + win[2] + win[3]) / 4;
`else
        expLum = convWord;
`endif
      end
      if (debFlip(histPir, debPir)) debPir = !debPir;
      if (debFlip(histIr, debIr)) debIr = !debIr;
      histPir = {histPir[DEB-1:0], pir_raw};
      histIr  = {histIr[DEB-1:0], ir_raw};
      if (debPir) sinceFall = 0;
      else if (sinceFall <= MH) sinceFall++;
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("cs_n", adc_cs_n, expCs);
      checkOutput("sclk", adc_sclk, expSclk);
      checkOutput("lum_sen", lum_sen, expLum);
      checkOutput("lum_valid", lum_valid, expValid);
      checkOutput("ir_sen", ir_sen, debIr);
      checkOutput("motion_sen", motion_sen, debPir || (sinceFall >= 1 && sinceFall <= MH));
      checkOutput("dflt_ir_sen", dfltIr, debIr);
      checkOutput("dflt_motion", dfltMotion, debPir || (sinceFall >= 1 && sinceFall <= MH));
    end
  end

  // Per-conversion statistics: select-low length and sclk pulse count.
  int csRun = 0, pulses = 0, lastCsLow = 0, lastPulses = 0;
  bit prevSclk = 0;
  always @(negedge clk) begin
    if (adc_cs_n === 1'b0) begin
      csRun++;
      if (adc_sclk && !prevSclk) pulses++;
    end else if (csRun > 0) begin
      lastCsLow = csRun; lastPulses = pulses; csRun = 0; pulses = 0;
    end
    prevSclk = adc_sclk;
  end

  bit dfltDone = 0;
  initial begin
    int found;
    found = 0;
    @(negedge reset);
    for (int i = 1; i <= 1100 && found == 0; i++) begin
      @(posedge clk); #1;
      if (dfltCs === 1'b0) begin
        found = i;
        checkOutput("dfltSclkAtSelect", dfltSclk, 0);
        checkOutput("dfltLumAtSelect", dfltLum, 0);
        checkOutput("dfltValidAtSelect", dfltValid, 0);
      end
    end
    checkOutput("dfltFirstCsFall", found, 1000);
    dfltDone = 1;
  end

  task automatic waitValid(input int maxCycles, output bit ok);
    ok = 0;
    for (int i = 0; i < maxCycles && !ok; i++) begin
      @(negedge clk);
      if (lum_valid === 1'b1) ok = 1;
    end
    if (!ok) checkOutput("lumValidTimeout", 0, 1);
  endtask

  task automatic waitCsFall(input int maxCycles, output bit ok);
    int i;
    ok = 0;
    for (i = 0; i < maxCycles && adc_cs_n !== 1'b1; i++) @(negedge clk);
    for (; i < maxCycles && !ok; i++) begin
      @(negedge clk);
      if (adc_cs_n === 1'b0) ok = 1;
    end
    if (!ok) checkOutput("csFallTimeout", 0, 1);
  endtask

  task automatic countDrops(input int cycles, inout int drops);
    repeat (cycles) begin
      @(posedge clk); #1;
      if (!motion_sen) drops++;
    end
  endtask

  initial begin
    bit ok;
    int first, seen, drops, valids;
    reset = 1'b1;
    applyStimulus(0, 0);
    repeat (5) @(negedge clk);
    checkOutput("rstCs", adc_cs_n, 1);
    checkOutput("rstSclk", adc_sclk, 0);
    checkOutput("rstLum", lum_sen, 0);
    checkOutput("rstValid", lum_valid, 0);
    checkOutput("rstMotion", motion_sen, 0);
    checkOutput("rstIr", ir_sen, 0);
    reset = 1'b0;

    adcWord = 8'h80;
    waitValid(400, ok);
    if (ok) begin
      checkOutput("lumFirst", lum_sen, EXP_FIRST);
      @(negedge clk);
      checkOutput("validWidth", lum_valid, 0);
      checkOutput("csLowLen", lastCsLow, 68);
      checkOutput("sclkPulses", lastPulses, 8);
    end
    adcWord = 8'h08;
    waitValid(300, ok);
    if (ok) checkOutput("lumSecond", lum_sen, EXP_SECOND);

    @(negedge clk); applyStimulus(0, 1);
    repeat (5) @(negedge clk);
    applyStimulus(0, 0);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (ir_sen) seen = 1; end
    checkOutput("irGlitch", seen, 0);
    @(negedge clk); applyStimulus(0, 1);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ir_sen && first == 0) first = i;
    end
    checkOutput("irLatency", first, 10);
    @(negedge clk); applyStimulus(0, 0);
    repeat (20) @(negedge clk);

    applyStimulus(1, 0);
    first = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (motion_sen && first == 0) first = i;
    end
    checkOutput("motionRise", first, 10);
    @(negedge clk); applyStimulus(0, 0);
    first = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (!motion_sen && first == 0) first = i;
    end
    checkOutput("motionHoldEnd", first, 74);

    @(negedge clk); applyStimulus(1, 0);
    repeat (12) @(posedge clk);
    #1 checkOutput("retrigRise", motion_sen, 1);
    drops = 0;
    countDrops(8, drops);
    @(negedge clk); applyStimulus(0, 0);
    countDrops(30, drops);
    @(negedge clk); applyStimulus(1, 0);
    countDrops(20, drops);
    @(negedge clk); applyStimulus(0, 0);
    countDrops(20, drops);
    checkOutput("retrigNoDrop", drops, 0);
    repeat (100) @(negedge clk);

    for (int i = 0; i < 1500 && !dfltDone; i++) @(negedge clk);
    if (!dfltDone) checkOutput("dfltTimeout", 0, 1);

    waitCsFall(400, ok);
    if (ok) begin
      repeat (38) @(negedge clk);
      checkOutput("midShiftCs", adc_cs_n, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("abortCs", adc_cs_n, 1);
      checkOutput("abortSclk", adc_sclk, 0);
      checkOutput("abortLum", lum_sen, 0);
      checkOutput("abortValid", lum_valid, 0);
      @(negedge clk); reset = 1'b0;
      valids = 0;
      repeat (150) begin @(negedge clk); if (lum_valid) valids++; end
      checkOutput("noValidAfterAbort", valids, 0);
      adcWord = 8'hA5;
      waitValid(200, ok);
      if (ok) checkOutput("lumAfterAbort", lum_sen, EXP_ABORT);
    end

    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adcWord = 8'(SEQ_WORDS[i]);
      waitValid(300, ok);
      if (ok) checkOutput($sformatf("lumSeq%0d", i), lum_sen, EXP_SEQ[i]);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
